inv_subbytes_seq: RTL and testbench

Multi-cycle InvSubBytes engine for the AES-128 decryption datapath. It accepts a 128-bit state over a valid/ready handshake and substitutes all 16 bytes through LANES instances of the team's `inverseSbox` lookup, LANES bytes per cycle. It returns the substituted state over a second valid/ready handshake. The block sits between InvShiftRows and AddRoundKey in the round loop, and trades lookup area against latency through LANES.

---
 rtl/inv_subbytes_seq.sv | 162 ++++++++++++++++
 tb/tb_inv_subbytes_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_subbytes_seq.sv
// ---------------------------------------------------------------------------
// inv_subbytes_seq
//   Multi-cycle InvSubBytes engine for the AES-128 decryption round loop.
//   A 128-bit state is accepted over a valid/ready handshake, its 16 bytes
//   are substituted LANES at a time through LANES inverseSbox lookups
//   (NCHUNK = 16/LANES cycles), and the result is returned over a second
//   valid/ready handshake.
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      synchronous active-low reset
//     abort      synchronous flush of any block in flight
//     in_valid   in_state is valid
//     in_ready   engine idle and able to accept a state
//     in_state   input state, byte 0 = in_state[127:120]
//     out_valid  out_state holds a finished block
//     out_ready  downstream accepts out_state
//     out_state  substituted state, same byte order as in_state
//     busy       a block is being processed or waiting for delivery
// ---------------------------------------------------------------------------
module inv_subbytes_seq #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         abort,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int unsigned NCHUNK = 16 / LANES;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned CW     = 8 * LANES;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [127:0]     work_q,  work_d;

  logic [CW-1:0]    chunk_in;
  logic [CW-1:0]    chunk_out;

  // Chunk cnt_q of work, most significant byte first (lane 0 = lowest byte index).
  always_comb begin
    chunk_in = '0;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        chunk_in = work_q[127 - CW*k -: CW];
      end
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    inverseSbox u_sbox (
      .in_byte  (chunk_in [CW-1-8*j -: 8]),
      .out_byte (chunk_out[CW-1-8*j -: 8])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int unsigned k = 0; k < NCHUNK; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            work_d[127 - CW*k -: CW] = chunk_out;
          end
        end
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush wins over both handshakes; work keeps its old contents.
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      work_d  = work_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign out_state = work_q;

endmodule

// ---------------------------------------------------------------------------
// inverseSbox
//   Combinational AES inverse S-box lookup.
//   Ports: in_byte (byte to substitute), out_byte (InvSbox(in_byte)).
// ---------------------------------------------------------------------------
module inverseSbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign out_byte = INV_SBOX[in_byte];

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// ---------------------------------------------------------------------------
// tb_inv_subbytes_seq
//   Five engines (LANES = 1, 2, 4, 8, 16) on one clock. The reference
//   inverse S-box is derived from GF(2^8) inversion and the AES affine map.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_inv_subbytes_seq;

  localparam int NDUT = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         abort     [NDUT];
  logic         in_valid  [NDUT];
  logic         out_ready [NDUT];
  logic [127:0] in_state  [NDUT];
  logic         in_ready  [NDUT];
  logic         out_valid [NDUT];
  logic         busy      [NDUT];
  logic [127:0] out_state [NDUT];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    inv_subbytes_seq #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .abort     (abort[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tab();
    logic [7:0] x, inv, s;
    for (int i = 0; i < 256; i++) begin
      x   = 8'(i);
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      inv_tab[s] = x;
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = inv_tab[s[127 - 8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a falling edge. Accepts din, waits for out_valid with
  // out_ready high, and returns after the delivery edge.
  task automatic run_block(input int idx, input logic [127:0] din,
                           output logic [127:0] dout, output int lat, output int busy_lo);
    in_valid[idx]  = 1'b1;
    in_state[idx]  = din;
    out_ready[idx] = 1'b1;
    @(negedge clk);
    in_valid[idx] = 1'b0;
    in_state[idx] = rnd128();
    lat = 0;
    busy_lo = 0;
    if (!busy[idx]) busy_lo++;
    while (!out_valid[idx] && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!busy[idx]) busy_lo++;
    end
    dout = out_state[idx];
    @(negedge clk);
    chk("ready_after_delivery", 128'(in_ready[idx]), 128'd1);
  endtask

  task automatic wait_valid(input int idx);
    int n = 0;
    while (!out_valid[idx] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_out_valid", 128'(out_valid[idx]), 128'd1);
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs [3];
    logic [127:0] dout, held, a, b;
    int           lat, blo, seen;

    vecs[0] = '{din: 128'h000102030405060708090a0b0c0d0e0f, dout: 128'h52096ad53036a538bf40a39e81f3d7fb};
    vecs[1] = '{din: {16{8'h63}}, dout: 128'h0};
    vecs[2] = '{din: {16{8'hff}}, dout: {16{8'h7d}}};

    build_tab();

    rst_n = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      abort[i] = 1'b0; in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_state[i] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk("reset_in_ready",  128'(in_ready[i]),  128'd1);
      chk("reset_out_valid", 128'(out_valid[i]), 128'd0);
      chk("reset_busy",      128'(busy[i]),      128'd0);
      chk("reset_out_state", out_state[i],       128'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors on LANES=4.
    for (int v = 0; v < 3; v++) begin
      run_block(2, vecs[v].din, dout, lat, blo);
      chk("vec_out",     dout,         vecs[v].dout);
      chk("vec_latency", 128'(lat),    128'd4);
      chk("vec_busy",    128'(blo),    128'd0);
    end

    // Backpressure: DONE held for 6 cycles, new in_valid ignored meanwhile.
    a = rnd128();
    b = rnd128();
    in_valid[2] = 1'b1; in_state[2] = a; out_ready[2] = 1'b0;
    @(negedge clk);
    in_valid[2] = 1'b0;
    wait_valid(2);
    held = out_state[2];
    chk("bp_out", held, model(a));
    in_valid[2] = 1'b1; in_state[2] = b;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("bp_valid_held", 128'(out_valid[2]), 128'd1);
      chk("bp_state_held", out_state[2],       held);
      chk("bp_in_ready",   128'(in_ready[2]),  128'd0);
    end
    out_ready[2] = 1'b1;
    @(negedge clk);
    chk("bp_idle_ready", 128'(in_ready[2]),  128'd1);
    chk("bp_idle_valid", 128'(out_valid[2]), 128'd0);
    chk("bp_idle_busy",  128'(busy[2]),      128'd0);
    @(negedge clk);
    in_valid[2] = 1'b0;
    chk("bp_accept_busy", 128'(busy[2]), 128'd1);
    wait_valid(2);
    chk("bp_second_out", out_state[2], model(b));
    @(negedge clk);

    // Abort mid-RUN at cnt=2, then abort together with in_valid in IDLE.
    in_valid[2] = 1'b1; in_state[2] = rnd128(); out_ready[2] = 1'b1;
    @(negedge clk);
    in_valid[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort[2] = 1'b1;
    @(negedge clk);
    chk("abort_in_ready",  128'(in_ready[2]),  128'd1);
    chk("abort_out_valid", 128'(out_valid[2]), 128'd0);
    chk("abort_busy",      128'(busy[2]),      128'd0);
    in_valid[2] = 1'b1; in_state[2] = rnd128();
    @(negedge clk);
    chk("abort_idle_in_ready", 128'(in_ready[2]), 128'd1);
    chk("abort_idle_busy",     128'(busy[2]),     128'd0);
    abort[2] = 1'b0; in_valid[2] = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid[2] || busy[2]) seen++;
    end
    chk("abort_no_pulse", 128'(seen), 128'd0);
    a = rnd128();
    run_block(2, a, dout, lat, blo);
    chk("abort_clean_out", dout, model(a));
    chk("abort_clean_lat", 128'(lat), 128'd4);

    // Reset mid-RUN.
    in_valid[2] = 1'b1; in_state[2] = rnd128(); out_ready[2] = 1'b1;
    @(negedge clk);
    in_valid[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_run_in_ready",  128'(in_ready[2]),  128'd1);
    chk("rst_run_out_valid", 128'(out_valid[2]), 128'd0);
    chk("rst_run_busy",      128'(busy[2]),      128'd0);
    chk("rst_run_out_state", out_state[2],       128'd0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid[2]) seen++;
    end
    chk("rst_run_no_pulse", 128'(seen), 128'd0);

    // Reset mid-DONE.
    in_valid[2] = 1'b1; in_state[2] = rnd128(); out_ready[2] = 1'b0;
    @(negedge clk);
    in_valid[2] = 1'b0;
    wait_valid(2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_done_in_ready",  128'(in_ready[2]),  128'd1);
    chk("rst_done_out_valid", 128'(out_valid[2]), 128'd0);
    chk("rst_done_busy",      128'(busy[2]),      128'd0);
    chk("rst_done_out_state", out_state[2],       128'd0);
    a = rnd128();
    run_block(2, a, dout, lat, blo);
    chk("rst_clean_out", dout, model(a));

    // Random sweep over every LANES value.
    for (int idx = 0; idx < NDUT; idx++) begin
      for (int n = 0; n < 200; n++) begin
        a = rnd128();
        run_block(idx, a, dout, lat, blo);
        chk("rand_out",     dout,      model(a));
        chk("rand_latency", 128'(lat), 128'(16 >> idx));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
